// File: rtl/pipelined_adder.sv
// pipelined_adder: WIDTH-bit add/sub whose carry chain is split over SEGMENTS register stages; valid/ready on both sides, whole pipe stalls together; define ADDER_SAT_EN to saturate sum
module pipelined_adder #(
  parameter int WIDTH    = 16,
  parameter int SEGMENTS = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             sub,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] sum,
  output logic             cout
);
  localparam int SW = WIDTH / SEGMENTS;
  logic [WIDTH-1:0]    a_q [SEGMENTS];
  logic [WIDTH-1:0]    b_q [SEGMENTS];
  logic [WIDTH-1:0]    s_q [SEGMENTS];
  logic                m_q [SEGMENTS];
  logic [SEGMENTS-1:0] c_q, v_q;
  logic [WIDTH-1:0]    ai [SEGMENTS];
  logic [WIDTH-1:0]    bi [SEGMENTS];
  logic [WIDTH-1:0]    si [SEGMENTS];
  logic [WIDTH-1:0]    sn [SEGMENTS];
  logic                ci [SEGMENTS];
  logic                mi [SEGMENTS];
  logic                vi [SEGMENTS];
  logic [SW:0]         r  [SEGMENTS];
  logic                stall;
  assign stall     = out_valid && !out_ready;
  assign in_ready  = !stall;
  assign out_valid = v_q[SEGMENTS-1];
  assign sum       = s_q[SEGMENTS-1];
  assign cout      = c_q[SEGMENTS-1];
  always_comb begin
    for (int k = 0; k < SEGMENTS; k++) begin
      if (k == 0) begin
        ai[k] = a;
        bi[k] = sub ? ~b : b;
        si[k] = '0;
        ci[k] = sub;
        mi[k] = sub;
        vi[k] = in_valid;
      end else begin
        ai[k] = a_q[k-1];
        bi[k] = b_q[k-1];
        si[k] = s_q[k-1];
        ci[k] = c_q[k-1];
        mi[k] = m_q[k-1];
        vi[k] = v_q[k-1];
      end
      r[k]  = {1'b0, ai[k][k*SW +: SW]} + {1'b0, bi[k][k*SW +: SW]} + (SW+1)'(ci[k]);
      sn[k] = si[k] | (WIDTH'(r[k][SW-1:0]) << (k * SW));
    end
`ifdef ADDER_SAT_EN
    sn[SEGMENTS-1] = mi[SEGMENTS-1] ? (r[SEGMENTS-1][SW] ? sn[SEGMENTS-1] : '0)
                                    : (r[SEGMENTS-1][SW] ? '1 : sn[SEGMENTS-1]);
`endif
  end
  always_ff @(posedge clk)
    if (rst) begin
      v_q <= '0;
      c_q <= '0;
      for (int k = 0; k < SEGMENTS; k++) begin
        a_q[k] <= '0;
        b_q[k] <= '0;
        s_q[k] <= '0;
        m_q[k] <= 1'b0;
      end
    end else if (!stall) begin
      for (int k = 0; k < SEGMENTS; k++) begin
        v_q[k] <= vi[k];
        if (vi[k]) begin
          a_q[k] <= ai[k];
          b_q[k] <= bi[k];
          s_q[k] <= sn[k];
          c_q[k] <= r[k][SW];
          m_q[k] <= mi[k];
        end
      end
    end
endmodule

// File: tb/tb_pipelined_adder.sv
// tb_pipelined_adder: checks pipelined_adder at SEGMENTS=4, 1 and 16 against an arithmetic reference model
module tb_pipelined_adder;
  logic clk = 1'b0;
  always #5 clk = ~clk;
  logic rst = 1'b1;
  logic iv [3], ir [3], sb [3], ov [3], ordy [3], co [3];
  logic [15:0] oa [3], ob [3], sm [3];
  int passed = 0, total = 0;
  for (genvar i = 0; i < 3; i++) begin : g_dut
    pipelined_adder #(.WIDTH(16), .SEGMENTS(i == 0 ? 4 : i == 1 ? 1 : 16)) dut (
      .clk(clk), .rst(rst), .in_valid(iv[i]), .in_ready(ir[i]), .a(oa[i]), .b(ob[i]),
      .sub(sb[i]), .out_valid(ov[i]), .out_ready(ordy[i]), .sum(sm[i]), .cout(co[i]));
  end
  function automatic logic [16:0] ref_add(input logic [15:0] x, input logic [15:0] y, input logic s);
    int unsigned t;
    logic c;
    logic [15:0] res;
    if (s) begin
      c   = x >= y;
      res = 16'(int'(x) - int'(y));
    end else begin
      t   = 32'(x) + 32'(y);
      c   = t > 32'd65535;
      res = 16'(t);
    end
`ifdef ADDER_SAT_EN
    if (!s && c) res = 16'hFFFF;
    if (s && !c) res = 16'h0000;
`endif
    return {c, res};
  endfunction
  function automatic logic [15:0] rnd16();
    int unsigned p;
    p = $urandom_range(0, 7);
    return p == 0 ? 16'hFFFF : p == 1 ? 16'h0000 : 16'($urandom);
  endfunction
  task automatic test_reset();
    rst = 1'b1;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    for (int d = 0; d < 3; d++) begin
      total++;
      if ({ov[d], sm[d], co[d], ir[d]} !== {1'b0, 16'h0000, 1'b0, 1'b1})
        $display("FAIL reset dut%0d: out_valid=%b sum=%h cout=%b in_ready=%b, want 0 0000 0 1", d, ov[d], sm[d], co[d], ir[d]);
      else passed++;
    end
  endtask
  task automatic test_single(input string nm, input logic [15:0] x, input logic [15:0] y,
                             input logic s, input logic [15:0] es, input logic ec);
    int lat = 0, nv = 0;
    logic [15:0] rs = 'x;
    logic rc = 1'bx;
    @(posedge clk);
    #1 iv[0] = 1'b1; oa[0] = x; ob[0] = y; sb[0] = s; ordy[0] = 1'b1;
    @(posedge clk);
    #1 iv[0] = 1'b0;
    for (int c = 1; c <= 8; c++) begin
      @(negedge clk);
      if (ov[0]) begin
        nv++;
        if (lat == 0) begin lat = c; rs = sm[0]; rc = co[0]; end
      end
    end
    total++;
    if (lat != 4) $display("FAIL %s latency: got %0d cycles, want 4", nm, lat); else passed++;
    total++;
    if (nv != 1) $display("FAIL %s output count: got %0d valid cycles, want 1", nm, nv); else passed++;
    total++;
    if (rs !== es) $display("FAIL %s sum: got %h, want %h", nm, rs, es); else passed++;
    total++;
    if (rc !== ec) $display("FAIL %s cout: got %b, want %b", nm, rc, ec); else passed++;
  endtask
  task automatic test_back_to_back();
    logic [16:0] q[$];
    logic [15:0] ca, cb, psum = '0;
    logic pco = 1'b0, pstall = 1'b0;
    int sent = 0, got = 0, cyc = 0, extra = 0;
    ca = rnd16(); cb = rnd16();
    while (got < 8 && cyc < 60) begin
      @(posedge clk);
      #1 iv[0] = sent < 8; oa[0] = ca; ob[0] = cb; sb[0] = 1'b0; ordy[0] = !(cyc >= 4 && cyc <= 6);
      @(negedge clk);
      if (cyc == 4) begin
        total++;
        if (ov[0] !== 1'b1) $display("FAIL b2b first result at cycle 4: out_valid=%b, want 1", ov[0]); else passed++;
      end
      if (pstall) begin
        total++;
        if ({ov[0], co[0], sm[0]} !== {1'b1, pco, psum})
          $display("FAIL b2b held output: got v=%b c=%b s=%h, want v=1 c=%b s=%h", ov[0], co[0], sm[0], pco, psum);
        else passed++;
      end
      total++;
      if (ir[0] !== !(ov[0] && !ordy[0]))
        $display("FAIL b2b in_ready cycle %0d: got %b, want %b", cyc, ir[0], !(ov[0] && !ordy[0]));
      else passed++;
      if (iv[0] && ir[0]) begin
        q.push_back(ref_add(ca, cb, 1'b0));
        sent++;
        ca = rnd16(); cb = rnd16();
      end
      if (ov[0] && ordy[0]) begin
        total++;
        if (q.size() == 0 || {co[0], sm[0]} !== q[0])
          $display("FAIL b2b result %0d: got c=%b s=%h, want %h", got, co[0], sm[0], q.size() ? q[0] : 17'h0);
        else passed++;
        if (q.size() != 0) void'(q.pop_front());
        got++;
      end
      pstall = ov[0] && !ordy[0]; psum = sm[0]; pco = co[0];
      cyc++;
    end
    iv[0] = 1'b0; ordy[0] = 1'b1;
    total++;
    if (got != 8 || sent != 8) $display("FAIL b2b count: sent %0d got %0d, want 8 8", sent, got); else passed++;
    repeat (6) begin
      @(negedge clk);
      if (ov[0]) extra++;
    end
    total++;
    if (extra != 0) $display("FAIL b2b duplicates: %0d extra valid cycles, want 0", extra); else passed++;
  endtask
  task automatic test_reset_mid();
    @(posedge clk);
    #1 ordy[0] = 1'b1;
    for (int i = 0; i < 3; i++) begin
      iv[0] = 1'b1; oa[0] = rnd16(); ob[0] = rnd16(); sb[0] = 1'($urandom);
      @(posedge clk);
      #1;
    end
    rst = 1'b1; iv[0] = 1'b1; oa[0] = rnd16(); ob[0] = rnd16();
    @(posedge clk);
    #1 rst = 1'b0; iv[0] = 1'b0;
    for (int c = 0; c < 5; c++) begin
      @(negedge clk);
      if (c == 0) begin
        total++;
        if (ir[0] !== 1'b1) $display("FAIL rst_mid in_ready after reset: got %b, want 1", ir[0]); else passed++;
      end
      total++;
      if (ov[0] !== 1'b0) $display("FAIL rst_mid out_valid cycle %0d after reset: got %b, want 0", c, ov[0]); else passed++;
    end
  endtask
  task automatic test_stream(input int d, input int n, input int segs);
    logic [16:0] q[$];
    int lq[$];
    logic [16:0] pv = '0;
    logic pheld = 1'b0, cs;
    logic [15:0] ca, cb;
    int stalls = 0, cyc = 0, sent = 0, got = 0, extra = 0;
    ca = rnd16(); cb = rnd16(); cs = 1'($urandom);
    while (got < n && cyc < n * 8) begin
      @(posedge clk);
      #1 iv[d] = sent < n && $urandom_range(0, 3) != 0; oa[d] = ca; ob[d] = cb; sb[d] = cs;
      ordy[d] = $urandom_range(0, 4) != 0;
      @(negedge clk);
      if (pheld) begin
        total++;
        if ({ov[d], co[d], sm[d]} !== {1'b1, pv})
          $display("FAIL stream%0d held output cycle %0d: got v=%b %h, want v=1 %h", segs, cyc, ov[d], {co[d], sm[d]}, pv);
        else passed++;
      end else if (ov[d]) begin
        total++;
        if (lq.size() == 0 || cyc - stalls - lq[0] != segs)
          $display("FAIL stream%0d latency cycle %0d: got %0d, want %0d", segs, cyc, lq.size() ? cyc - stalls - lq[0] : -1, segs);
        else passed++;
      end
      if (iv[d] && ir[d]) begin
        q.push_back(ref_add(ca, cb, cs));
        lq.push_back(cyc - stalls);
        sent++;
        ca = rnd16(); cb = rnd16(); cs = 1'($urandom);
      end
      if (ov[d] && ordy[d]) begin
        total++;
        if (q.size() == 0 || {co[d], sm[d]} !== q[0])
          $display("FAIL stream%0d result %0d: got %h, want %h", segs, got, {co[d], sm[d]}, q.size() ? q[0] : 17'h0);
        else passed++;
        if (q.size() != 0) begin void'(q.pop_front()); void'(lq.pop_front()); end
        got++;
      end
      pheld = ov[d] && !ordy[d];
      pv = {co[d], sm[d]};
      if (pheld) stalls++;
      cyc++;
    end
    iv[d] = 1'b0; ordy[d] = 1'b1;
    total++;
    if (got != n || q.size() != 0) $display("FAIL stream%0d count: got %0d pending %0d, want %0d 0", segs, got, q.size(), n); else passed++;
    repeat (segs + 3) begin
      @(negedge clk);
      if (ov[d]) extra++;
    end
    total++;
    if (extra != 0) $display("FAIL stream%0d extra outputs: %0d, want 0", segs, extra); else passed++;
  endtask
  initial begin
    for (int d = 0; d < 3; d++) begin
      iv[d] = 1'b0; ordy[d] = 1'b1; oa[d] = '0; ob[d] = '0; sb[d] = 1'b0;
    end
    test_reset();
    test_single("add", 16'h1234, 16'h4321, 1'b0, 16'h5555, 1'b0);
`ifdef ADDER_SAT_EN
    test_single("carry", 16'hFFFF, 16'h0001, 1'b0, 16'hFFFF, 1'b1);
    test_single("borrow", 16'h0005, 16'h0007, 1'b1, 16'h0000, 1'b0);
`else
    test_single("carry", 16'hFFFF, 16'h0001, 1'b0, 16'h0000, 1'b1);
    test_single("borrow", 16'h0005, 16'h0007, 1'b1, 16'hFFFE, 1'b0);
`endif
    test_single("no_borrow", 16'h0007, 16'h0005, 1'b1, 16'h0002, 1'b1);
    test_back_to_back();
    test_reset_mid();
    test_stream(0, 300, 4);
    test_stream(1, 1000, 1);
    test_stream(2, 1000, 16);
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule
